// File: rtl/mmc_trig_sequencer.sv
// rtl/mmc_trig_sequencer.sv - MMC command-packet trigger sequencer with register bank
module mmc_trig_sequencer (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    input  logic        reg_read,
    input  logic        reg_write,
    output logic [7:0]  reg_datao,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic [47:0] msg_packet,
    input  logic        msg_valid,
    output logic        trig_out,
    output logic [1:0]  state_o,
    output logic [1:0]  step_o
);

    localparam logic [5:0] ADDR_STEPS  = 6'd60;
    localparam logic [5:0] ADDR_CTRL   = 6'd61;
    localparam logic [5:0] ADDR_STATUS = 6'd62;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] FIRE  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_EQ = 2'd0;
    localparam logic [1:0] OP_NE = 2'd1;
    localparam logic [1:0] OP_LT = 2'd2;
    localparam logic [1:0] OP_GT = 2'd3;

    // Last fire_cnt value of a 127-cycle pulse (counter starts at 0).
    localparam logic [6:0] FIRE_LAST = 7'd126;

    logic [255:0] steps;
    logic [15:0]  ctrl;
    logic [1:0]   state;
    logic [1:0]   step;
    logic [7:0]   miss_cnt;
    logic         fired;
    logic [6:0]   fire_cnt;

    logic         steps_wr;
    logic         ctrl_wr;
    logic         arm_wr;
    logic         status_rd;
    logic [1:0]   last_step;
    logic [7:0]   timeout;
    logic [7:0]   miss_next;
    logic [63:0]  cur_step;
    logic [31:0]  pkt_data;
    logic [31:0]  cmp_data;
    logic         cmp_hit;
    logic         step_match;
    logic [7:0]   status_byte;
    logic [7:0]   rd_byte;
    logic         unused_bits;

    assign steps_wr  = reg_write && (reg_address == ADDR_STEPS) && (reg_bytecnt < 16'd32);
    assign ctrl_wr   = reg_write && (reg_address == ADDR_CTRL) && (reg_bytecnt < 16'd2);
    assign arm_wr    = ctrl_wr && (reg_bytecnt == 16'd0);
    assign status_rd = reg_read && (reg_address == ADDR_STATUS) && (reg_bytecnt == 16'd0);

    assign last_step = ctrl[2:1];
    assign timeout   = ctrl[15:8];
    assign miss_next = miss_cnt + 8'd1;

    assign cur_step  = steps[{step, 6'b0} +: 64];
    assign pkt_data  = msg_packet[39:8];
    assign cmp_data  = cur_step[63:32];

    always_comb begin
        cmp_hit = 1'b0;
        case (cur_step[5:4])
            OP_EQ:   cmp_hit = (pkt_data == cmp_data);
            OP_NE:   cmp_hit = (pkt_data != cmp_data);
            OP_LT:   cmp_hit = (pkt_data <  cmp_data);
            OP_GT:   cmp_hit = (pkt_data >  cmp_data);
            default: cmp_hit = 1'b0;
        endcase
    end

    assign step_match = (cmp_hit || !cur_step[2])
                     && ((msg_packet[45:40] == cur_step[29:24]) || !cur_step[1])
                     && ((msg_packet[46] == cur_step[30]) || !cur_step[0]);

    assign status_byte = {3'b000, fired, step, state};

    always_comb begin
        rd_byte = 8'h00;
        case (reg_address)
            ADDR_STEPS: begin
                if (reg_bytecnt < 16'd32)
                    rd_byte = steps[{reg_bytecnt[4:0], 3'b000} +: 8];
            end
            ADDR_CTRL: begin
                if (reg_bytecnt == 16'd0)
                    rd_byte = ctrl[7:0];
                else if (reg_bytecnt == 16'd1)
                    rd_byte = ctrl[15:8];
            end
            ADDR_STATUS: begin
                if (reg_bytecnt == 16'd0)
                    rd_byte = status_byte;
            end
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        reg_hyplen = 16'd0;
        case (reg_hypaddress)
            ADDR_STEPS:  reg_hyplen = 16'd32;
            ADDR_CTRL:   reg_hyplen = 16'd2;
            ADDR_STATUS: reg_hyplen = 16'd1;
            default:     reg_hyplen = 16'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            steps     <= '0;
            ctrl      <= '0;
            state     <= IDLE;
            step      <= 2'd0;
            miss_cnt  <= 8'd0;
            fired     <= 1'b0;
            fire_cnt  <= 7'd0;
            reg_datao <= 8'h00;
        end else begin
            if (steps_wr)
                steps[{reg_bytecnt[4:0], 3'b000} +: 8] <= reg_datai;
            if (ctrl_wr) begin
                if (reg_bytecnt[0])
                    ctrl[15:8] <= reg_datai;
                else
                    ctrl[7:0] <= reg_datai;
            end
            if (reg_read)
                reg_datao <= rd_byte;
            if (status_rd)
                fired <= 1'b0;

            case (state)
                IDLE: begin
                    if (arm_wr && reg_datai[0]) begin
                        state    <= ARMED;
                        step     <= 2'd0;
                        miss_cnt <= 8'd0;
                    end
                end
                ARMED: begin
                    // Any CTRL write wins over a coincident packet, which is dropped.
                    if (ctrl_wr) begin
                        if (arm_wr && !reg_datai[0])
                            state <= IDLE;
                    end else if (msg_valid) begin
                        if (step_match) begin
                            // >= so that lowering last_step below the live step still fires.
                            if (step >= last_step) begin
                                state    <= FIRE;
                                fired    <= 1'b1;
                                ctrl[0]  <= 1'b0;
                                fire_cnt <= 7'd0;
                            end else begin
                                step     <= step + 2'd1;
                                miss_cnt <= 8'd0;
                            end
                        end else if ((step != 2'd0) && (timeout != 8'd0)) begin
                            if (miss_next == timeout) begin
                                step     <= 2'd0;
                                miss_cnt <= 8'd0;
                            end else begin
                                miss_cnt <= miss_next;
                            end
                        end
                    end
                end
                FIRE: begin
                    if (arm_wr && !reg_datai[0])
                        state <= IDLE;
                    else if (fire_cnt == FIRE_LAST)
                        state <= DONE;
                    else
                        fire_cnt <= fire_cnt + 7'd1;
                end
                DONE: begin
                    if (arm_wr && reg_datai[0]) begin
                        state    <= ARMED;
                        step     <= 2'd0;
                        miss_cnt <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from the async-reset state register so reset drops it without a clock.
    assign trig_out = (state == FIRE);
    assign state_o  = state;
    assign step_o   = step;

    assign unused_bits = ^{msg_packet[47], msg_packet[7:0], cur_step[31], cur_step[23:6], cur_step[3]};

endmodule

// File: tb/tb_mmc_trig_sequencer.sv
// tb/tb_mmc_trig_sequencer.sv - scoreboard bench for mmc_trig_sequencer
`timescale 1ns/1ps
module tb_mmc_trig_sequencer;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  reg_address = '0;
    logic [15:0] reg_bytecnt = '0;
    logic [7:0]  reg_datai = '0;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_datao;
    logic [5:0]  reg_hypaddress = '0;
    logic [15:0] reg_hyplen;
    logic [47:0] msg_packet = '0;
    logic        msg_valid = 1'b0;
    logic        trig_out;
    logic [1:0]  state_o;
    logic [1:0]  step_o;

    always #5 clk = ~clk;

    mmc_trig_sequencer dut (
        .clk(clk), .reset_i(reset_i),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
        .reg_read(reg_read), .reg_write(reg_write), .reg_datao(reg_datao),
        .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
        .msg_packet(msg_packet), .msg_valid(msg_valid),
        .trig_out(trig_out), .state_o(state_o), .step_o(step_o)
    );

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    int pulse_q[$];
    int run_len = 0;
    int last_pulse = 0;
    int pulse_cnt = 0;

    // Measures each trig_out high run in clk cycles.
    always @(negedge clk) begin
        if (trig_out)
            run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_pulse <= run_len;
            pulse_cnt  <= pulse_cnt + 1;
            run_len    <= 0;
        end
    end

    function automatic logic [63:0] mk_step(input logic [31:0] cmp, input logic tx, input logic [5:0] cmd,
                                            input logic [1:0] op, input logic den, input logic cen, input logic ten);
        return {cmp, 1'b0, tx, cmd, 18'b0, op, 1'b0, den, cen, ten};
    endfunction

    task automatic do_reset;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
        reg_address = a; reg_bytecnt = b; reg_datai = d; reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [15:0] b);
        reg_address = a; reg_bytecnt = b; reg_read = 1'b1;
        @(negedge clk);
        reg_read = 1'b0;
    endtask

    task automatic write_step(input int k, input logic [63:0] v);
        for (int i = 0; i < 8; i++)
            bus_write(6'd60, 16'(8 * k + i), v[8 * i +: 8]);
    endtask

    task automatic write_ctrl(input logic arm, input logic [1:0] last, input logic [7:0] tmo);
        bus_write(6'd61, 16'd1, tmo);
        bus_write(6'd61, 16'd0, {5'b0, last, arm});
    endtask

    task automatic send_pkt(input logic [5:0] cmd, input logic [31:0] data, input logic tx);
        msg_packet = {1'b0, tx, cmd, data, 8'h00};
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int start, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pulse_cnt != start) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [5:0]  ha [5];
        logic [15:0] hl [5];
        logic [7:0]  e;
        ha = '{6'd60, 6'd61, 6'd62, 6'd0, 6'd63};
        hl = '{16'd32, 16'd2, 16'd1, 16'd0, 16'd0};
        #1;
        n_assert++;
        if ({state_o, step_o, trig_out, reg_datao} !== 13'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b exp 0", {state_o, step_o, trig_out, reg_datao});
        end
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            reg_hypaddress = ha[i];
            #1;
            n_assert++;
            if (reg_hyplen !== hl[i]) begin
                n_fail++; $display("FAIL hyplen addr %0d got %0d exp %0d", ha[i], reg_hyplen, hl[i]);
            end
        end
        bus_write(6'd61, 16'd2, 8'h01);
        n_assert++;
        if (state_o !== 2'd0) begin
            n_fail++; $display("FAIL ctrl_beyond_len state got %0d exp 0", state_o);
        end
        bus_write(6'd60, 16'd32, 8'hFF);
        exp_q.push_back(8'h00); bus_read(6'd60, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin
            n_fail++; $display("FAIL steps_beyond_len got %h exp %h", reg_datao, e);
        end
    endtask

    task automatic test_single;
        logic [7:0] e;
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h0, 1'b0, 6'd17, 2'b00, 1'b0, 1'b1, 1'b0));
        write_ctrl(1'b1, 2'd0, 8'd0);
        n_assert++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL single_armed state got %0d exp 1", state_o); end
        exp_q.push_back(8'h01); bus_read(6'd61, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL ctrl_readback got %h exp %h", reg_datao, e); end
        exp_q.push_back(8'h00); bus_read(6'd20, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL unmapped_read got %h exp %h", reg_datao, e); end
        pc = pulse_cnt;
        send_pkt(6'd17, 32'h0, 1'b0);
        pulse_q.push_back(127);
        n_assert++;
        if ({state_o, trig_out} !== 3'b101) begin
            n_fail++; $display("FAIL single_trig_start got %b exp 101", {state_o, trig_out});
        end
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL single_pulse_len got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
        exp_q.push_back(8'h13); bus_read(6'd62, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL single_status got %h exp %h", reg_datao, e); end
        exp_q.push_back(8'h03); bus_read(6'd62, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL fired_clear got %h exp %h", reg_datao, e); end
        exp_q.push_back(8'h00); bus_read(6'd61, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL arm_cleared got %h exp %h", reg_datao, e); end
        send_pkt(6'd17, 32'h0, 1'b0);
        n_assert++;
        if ({state_o, trig_out} !== 3'b110) begin
            n_fail++; $display("FAIL done_ignores_pkt got %b exp 110", {state_o, trig_out});
        end
        write_ctrl(1'b1, 2'd0, 8'd0);
        n_assert++;
        if ({state_o, step_o} !== 4'b0100) begin
            n_fail++; $display("FAIL rearm_from_done got %b exp 0100", {state_o, step_o});
        end
        pc = pulse_cnt;
        send_pkt(6'd17, 32'h0, 1'b0);
        pulse_q.push_back(127);
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL back_to_back_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
    endtask

    task automatic test_two_step(input logic [7:0] tmo);
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h0, 1'b0, 6'd18, 2'b00, 1'b0, 1'b1, 1'b0));
        write_step(1, mk_step(32'h0, 1'b0, 6'd12, 2'b00, 1'b1, 1'b1, 1'b0));
        write_ctrl(1'b1, 2'd1, tmo);
        send_pkt(6'd18, 32'h0, 1'b0);
        n_assert++;
        if ({state_o, step_o, trig_out} !== 5'b01010) begin
            n_fail++; $display("FAIL two_step_adv tmo %0d got %b exp 01010", tmo, {state_o, step_o, trig_out});
        end
        if (tmo == 8'd0) begin
            send_pkt(6'd12, 32'h5, 1'b0);
            send_pkt(6'd13, 32'h0, 1'b0);
            send_pkt(6'd13, 32'h0, 1'b0);
            n_assert++;
            if ({state_o, step_o, trig_out} !== 5'b01010) begin
                n_fail++; $display("FAIL two_step_nofire got %b exp 01010", {state_o, step_o, trig_out});
            end
            pc = pulse_cnt;
            send_pkt(6'd12, 32'h0, 1'b0);
            pulse_q.push_back(127);
            n_assert++;
            if (trig_out !== 1'b1) begin n_fail++; $display("FAIL two_step_fire got %b exp 1", trig_out); end
            wait_pulse(pc, to);
            ep = pulse_q.pop_front(); n_assert++;
            if (to || last_pulse != ep) begin
                n_fail++; $display("FAIL two_step_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
            end
        end else begin
            send_pkt(6'd13, 32'h0, 1'b0);
            n_assert++;
            if (step_o !== 2'd1) begin n_fail++; $display("FAIL timeout_first_miss step got %0d exp 1", step_o); end
            send_pkt(6'd13, 32'h0, 1'b0);
            n_assert++;
            if (step_o !== 2'd0) begin n_fail++; $display("FAIL timeout_expire step got %0d exp 0", step_o); end
            send_pkt(6'd12, 32'h0, 1'b0);
            n_assert++;
            if ({state_o, step_o, trig_out} !== 5'b01000) begin
                n_fail++; $display("FAIL timeout_nofire got %b exp 01000", {state_o, step_o, trig_out});
            end
        end
    endtask

    task automatic test_gt_tx;
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h1000, 1'b1, 6'd0, 2'b11, 1'b1, 1'b0, 1'b1));
        write_ctrl(1'b1, 2'd0, 8'd0);
        send_pkt(6'd5, 32'h1000, 1'b1);
        n_assert++;
        if ({state_o, trig_out} !== 3'b010) begin
            n_fail++; $display("FAIL gt_equal_nofire got %b exp 010", {state_o, trig_out});
        end
        send_pkt(6'd5, 32'h1001, 1'b0);
        n_assert++;
        if ({state_o, trig_out} !== 3'b010) begin
            n_fail++; $display("FAIL gt_tx_mismatch got %b exp 010", {state_o, trig_out});
        end
        pc = pulse_cnt;
        send_pkt(6'd5, 32'h1001, 1'b1);
        pulse_q.push_back(127);
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL gt_fire_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
    endtask

    task automatic test_live_update;
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h0, 1'b0, 6'd18, 2'b00, 1'b0, 1'b1, 1'b0));
        write_step(1, mk_step(32'h0, 1'b0, 6'd12, 2'b00, 1'b0, 1'b1, 1'b0));
        write_ctrl(1'b1, 2'd1, 8'd0);
        send_pkt(6'd18, 32'h0, 1'b0);
        write_step(1, mk_step(32'h0, 1'b0, 6'd20, 2'b00, 1'b0, 1'b1, 1'b0));
        send_pkt(6'd12, 32'h0, 1'b0);
        n_assert++;
        if ({state_o, step_o, trig_out} !== 5'b01010) begin
            n_fail++; $display("FAIL live_update_old_cmd got %b exp 01010", {state_o, step_o, trig_out});
        end
        pc = pulse_cnt;
        send_pkt(6'd20, 32'h0, 1'b0);
        pulse_q.push_back(127);
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL live_update_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
    endtask

    task automatic test_disarm_reset;
        logic [7:0] e;
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h0, 1'b0, 6'd17, 2'b00, 1'b0, 1'b1, 1'b0));
        write_ctrl(1'b1, 2'd0, 8'd0);
        pc = pulse_cnt;
        send_pkt(6'd17, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        bus_write(6'd61, 16'd0, 8'h00);
        pulse_q.push_back(10);
        n_assert++;
        if ({state_o, trig_out} !== 3'b000) begin
            n_fail++; $display("FAIL disarm_in_fire got %b exp 000", {state_o, trig_out});
        end
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL disarm_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
        write_ctrl(1'b1, 2'd0, 8'd0);
        pc = pulse_cnt;
        send_pkt(6'd17, 32'h0, 1'b0);
        repeat (49) @(negedge clk);
        #2;
        reset_i = 1'b1;
        pulse_q.push_back(50);
        #1;
        n_assert++;
        if ({state_o, trig_out} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset_drop got %b exp 000", {state_o, trig_out});
        end
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL reset_pulse got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
        reset_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'h00); bus_read(6'd60, 16'(i)); e = exp_q.pop_front(); n_assert++;
            if (reg_datao !== e) begin n_fail++; $display("FAIL steps_after_reset byte %0d got %h exp %h", i, reg_datao, e); end
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h00); bus_read(6'd61, 16'(i)); e = exp_q.pop_front(); n_assert++;
            if (reg_datao !== e) begin n_fail++; $display("FAIL ctrl_after_reset byte %0d got %h exp %h", i, reg_datao, e); end
        end
        exp_q.push_back(8'h00); bus_read(6'd62, 16'd0); e = exp_q.pop_front(); n_assert++;
        if (reg_datao !== e) begin n_fail++; $display("FAIL status_after_reset got %h exp %h", reg_datao, e); end
    endtask

    task automatic test_collision;
        int pc, ep;
        bit to;
        do_reset;
        write_step(0, mk_step(32'h0, 1'b0, 6'd17, 2'b00, 1'b0, 1'b1, 1'b0));
        reg_address = 6'd61; reg_bytecnt = 16'd0; reg_datai = 8'h01; reg_write = 1'b1;
        msg_packet = {2'b00, 6'd17, 32'h0, 8'h00}; msg_valid = 1'b1;
        @(negedge clk);
        reg_write = 1'b0; msg_valid = 1'b0;
        n_assert++;
        if ({state_o, step_o, trig_out} !== 5'b01000) begin
            n_fail++; $display("FAIL collision_idle got %b exp 01000", {state_o, step_o, trig_out});
        end
        reg_write = 1'b1; msg_valid = 1'b1;
        @(negedge clk);
        reg_write = 1'b0; msg_valid = 1'b0;
        n_assert++;
        if ({state_o, step_o, trig_out} !== 5'b01000) begin
            n_fail++; $display("FAIL collision_armed got %b exp 01000", {state_o, step_o, trig_out});
        end
        pc = pulse_cnt;
        send_pkt(6'd17, 32'h0, 1'b0);
        pulse_q.push_back(127);
        wait_pulse(pc, to);
        ep = pulse_q.pop_front(); n_assert++;
        if (to || last_pulse != ep) begin
            n_fail++; $display("FAIL collision_then_fire got %0d exp %0d timeout %0b", last_pulse, ep, to);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_two_step(8'd0);
        test_two_step(8'd2);
        test_gt_tx;
        test_live_update;
        test_disarm_reset;
        test_collision;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmc_trig_sequencer.md
MMC_TRIG_SEQUENCER -- requirements
Module: mmc_trig_sequencer

Interface
REQ-001 SHALL have clk (input, 1): system clock; all logic is on its rising edge.
REQ-002 SHALL have reset_i (input, 1): asynchronous, active-high reset.
REQ-003 SHALL have reg_address (input, 6), reg_bytecnt (input, 16), reg_datai (input, 8), reg_read (input, 1), reg_write (input, 1): register bus.
REQ-004 SHALL have reg_datao (output, 8): registered read data.
REQ-005 SHALL have reg_hypaddress (input, 6) and reg_hyplen (output, 16): combinational register length lookup.
REQ-006 SHALL have msg_packet (input, 48) and msg_valid (input, 1): decoded MMC command packet; msg_valid is a one-clk pulse, already in the clk domain.
REQ-007 SHALL have trig_out (output, 1): stretched trigger pulse.
REQ-008 SHALL have state_o (output, 2) and step_o (output, 2): debug copies of the FSM state and the current step index.

Function
REQ-009 SHALL decode register addresses as follows: STEPS = 60 (32 bytes), CTRL = 61 (2 bytes), STATUS = 62 (1 byte, read-only); reg_hyplen SHALL be 0 for any other address.
REQ-010 SHALL store multi-byte registers little-endian: byte n = bits [8n+7:8n].
REQ-011 SHALL store step k (0..3) in STEPS bytes 8k..8k+7, 64 bits, with these fields:
- [63:32] compare data
- [30] tx bit
- [29:24] cmd
- [5:4] op (00 EQ, 01 NE, 10 LT, 11 GT; unsigned)
- [2] data_en, [1] cmd_en, [0] tx_en
REQ-012 SHALL define CTRL as: [0] arm, [2:1] last_step (0..3), [15:8] timeout (packets; 0 = disabled).
REQ-013 SHALL define STATUS as: [1:0] state, [3:2] step, [4] fired (sticky), [7:5] 0.
REQ-014 SHALL present read data on reg_datao one cycle after reg_read; unmapped addresses read as 0.
REQ-015 SHALL treat step k as matched when all three conditions hold:
- (msg_packet[39:8] op data) or !data_en
- (msg_packet[45:40] == cmd) or !cmd_en
- (msg_packet[46] == tx) or !tx_en
REQ-016 SHALL implement FSM states IDLE=0, ARMED=1, FIRE=2, DONE=3.
REQ-017 SHALL transition IDLE->ARMED with step=0 and miss_cnt=0 on a write of arm=1.
REQ-018 SHALL, in ARMED, on msg_valid with a step match where step<last_step: increment step and clear miss_cnt.
REQ-019 SHALL, in ARMED, on msg_valid with a step match where step==last_step: go to FIRE, set fired, clear arm.
REQ-020 SHALL, in ARMED with step>0 and timeout!=0, on a msg_valid without a match: increment miss_cnt (8-bit); when the incremented value equals timeout, set step=0 and miss_cnt=0.
REQ-021 SHALL ignore non-matching packets while step==0.
REQ-022 SHALL assert trig_out in FIRE for exactly 127 clk cycles, starting the cycle after the final-match msg_valid, then move to DONE.
REQ-023 SHALL hold trig_out low in all states other than FIRE.
REQ-024 SHALL, in DONE, return to ARMED (step=0) on a write of arm=1; fired stays set until the STATUS register is read.
REQ-025 SHALL, on a write of arm=0 in ARMED or FIRE, go to IDLE and drop trig_out the next cycle.
REQ-026 SHALL let a CTRL write take precedence when it coincides with msg_valid; that packet is ignored.
REQ-027 SHALL apply STEPS or last_step writes made while ARMED from the next packet onward; the current step index is not altered.
REQ-028 SHALL ignore msg_valid in IDLE, FIRE and DONE.
REQ-029 SHALL make reg writes beyond a register's length no-ops.

Reset
REQ-030 SHALL, on reset_i, set the following immediately and asynchronously: state=IDLE, step=0, miss_cnt=0, fired=0, trig_out=0, reg_datao=0, STEPS=0, CTRL=0.
REQ-031 SHALL, on reset_i asserted during FIRE, drop trig_out within the same cycle, without waiting for a clk edge.

Verification
REQ-032 SHALL pass the single-step scenario: step0 = {cmd=17, cmd_en}, last_step=0, arm; send a packet with cmd 17 -> trig_out high 127 cycles starting 1 cycle later; STATUS = 0x13 (DONE, fired).
REQ-033 SHALL pass the two-step scenario: step0 cmd=18, step1 {cmd=12, data EQ 0x00000000}, last_step=1; send cmd18, then cmd12 with data 5 (no fire), then cmd12 with data 0 -> fire on the third packet.
REQ-034 SHALL pass the timeout scenario: same two steps, timeout=2; send cmd18, cmd13, cmd13, cmd12/data0 -> no fire; step_o returns to 0 after the second cmd13.
REQ-035 SHALL pass the GT/tx scenario: step0 {op=GT, data=0x1000, tx=1, tx_en}; send data 0x1000 -> no fire; send data 0x1001 with tx=1 -> fire.
REQ-036 SHALL pass the disarm/reset scenario: write arm=0 at trig_out cycle 10 -> trig_out low next cycle, state IDLE; re-arm, match, assert reset_i at cycle 50 of FIRE -> trig_out low immediately, all registers read 0.
REQ-037 SHALL pass the collision scenario: a CTRL arm write in the same cycle as a matching msg_valid -> no fire; state ARMED, step 0.
